// File: rtl/udp_rs_encode_in_datap_if.sv
// udp_rs_encode_in_datap_if: NoC inbound, metadata and encoder-stream handshakes of the RX front end
interface udp_rs_encode_in_datap_if #(
  parameter int NOC_DATA_W   = 512,
  parameter int NUM_BLOCKS_W = 8
);
  localparam int PW = $clog2(NOC_DATA_W / 8);
  logic                    noc0_ctovr_udp_app_in_val;
  logic [NOC_DATA_W-1:0]   noc0_ctovr_udp_app_in_data;
  logic                    udp_app_in_noc0_ctovr_rdy;
  logic                    in_out_meta_val;
  logic                    out_in_meta_rdy;
  logic [31:0]             in_out_src_ip;
  logic [31:0]             in_out_dst_ip;
  logic [15:0]             in_out_src_port;
  logic [15:0]             in_out_dst_port;
  logic [15:0]             in_out_data_len;
  logic [NUM_BLOCKS_W-1:0] in_out_num_blocks;
  logic                    in_encoder_data_val;
  logic [NOC_DATA_W-1:0]   in_encoder_data;
  logic                    in_encoder_data_last;
  logic [PW-1:0]           in_encoder_data_padbytes;
  logic                    encoder_in_data_rdy;
  modport master (
    output noc0_ctovr_udp_app_in_val, noc0_ctovr_udp_app_in_data, out_in_meta_rdy, encoder_in_data_rdy,
    input  udp_app_in_noc0_ctovr_rdy, in_out_meta_val, in_out_src_ip, in_out_dst_ip, in_out_src_port,
           in_out_dst_port, in_out_data_len, in_out_num_blocks, in_encoder_data_val, in_encoder_data,
           in_encoder_data_last, in_encoder_data_padbytes
  );
  modport slave (
    input  noc0_ctovr_udp_app_in_val, noc0_ctovr_udp_app_in_data, out_in_meta_rdy, encoder_in_data_rdy,
    output udp_app_in_noc0_ctovr_rdy, in_out_meta_val, in_out_src_ip, in_out_dst_ip, in_out_src_port,
           in_out_dst_port, in_out_data_len, in_out_num_blocks, in_encoder_data_val, in_encoder_data,
           in_encoder_data_last, in_encoder_data_padbytes
  );
endinterface

// File: rtl/udp_rs_encode_in_datap.sv
// udp_rs_encode_in_datap: parses UDP RX NoC messages into metadata for the out path and a payload stream for the encoder
module udp_rs_encode_in_datap #(
  parameter int SRC_X        = -1,
  parameter int SRC_Y        = -1,
  parameter int NOC_DATA_W   = 512,
  parameter int NUM_BLOCKS_W = 8
) (
  input logic clk,
  input logic rst_n,
  udp_rs_encode_in_datap_if.slave bus
);
  localparam int BY = NOC_DATA_W / 8;
  localparam int PW = $clog2(BY);
  localparam int CW = 16 - PW;
  if (SRC_X < -1 || SRC_Y < -1) begin : g_bad_coord
    $error("tile coordinates must be >= -1");
  end
  typedef enum logic [2:0] {HDR, META, REQ, MOUT, DATA} state_t;
  state_t state, nxt;
  logic [NOC_DATA_W-1:0] d;
  logic [15:0] data_len, pay_len, in_len;
  logic [CW-1:0] cnt, data_flits;
  logic [PW-1:0] rem;
  logic fire, last;
  assign d        = bus.noc0_ctovr_udp_app_in_data;
  assign in_len   = d[NOC_DATA_W-97 -: 16];
  assign fire     = bus.noc0_ctovr_udp_app_in_val & bus.udp_app_in_noc0_ctovr_rdy;
  // the request-header flit occupies the first flit's worth of the UDP payload
  assign pay_len    = data_len > 16'(BY) ? data_len - 16'(BY) : '0;
  assign rem        = pay_len[PW-1:0];
  assign data_flits = pay_len[15:PW] + CW'(|rem);
  assign last       = state == DATA && cnt == data_flits - CW'(1);
  assign bus.in_encoder_data   = d;
  assign bus.in_out_data_len   = data_len;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HDR;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      HDR:     if (fire) nxt = META;
      META:    if (fire) nxt = in_len < 16'(BY) ? MOUT : REQ;
      REQ:     if (fire) nxt = MOUT;
      MOUT:    if (bus.out_in_meta_rdy) nxt = data_flits == '0 ? HDR : DATA;
      DATA:    if (fire && last) nxt = HDR;
      default: nxt = HDR;
    endcase
  end
  // rst_n gating keeps every handshake output low for the whole reset pulse
  always_comb begin
    bus.udp_app_in_noc0_ctovr_rdy = rst_n && (state == HDR || state == META || state == REQ ||
                                              (state == DATA && bus.encoder_in_data_rdy));
    bus.in_out_meta_val           = rst_n && state == MOUT;
    bus.in_encoder_data_val       = rst_n && state == DATA && bus.noc0_ctovr_udp_app_in_val;
    bus.in_encoder_data_last      = rst_n && last;
    bus.in_encoder_data_padbytes  = (rst_n && last) ? ~rem + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.in_out_src_ip     <= '0;
      bus.in_out_dst_ip     <= '0;
      bus.in_out_src_port   <= '0;
      bus.in_out_dst_port   <= '0;
      data_len              <= '0;
      bus.in_out_num_blocks <= '0;
      cnt                   <= '0;
    end else begin
      if (state == META && fire) begin
        bus.in_out_src_ip   <= d[NOC_DATA_W-1 -: 32];
        bus.in_out_dst_ip   <= d[NOC_DATA_W-33 -: 32];
        bus.in_out_src_port <= d[NOC_DATA_W-65 -: 16];
        bus.in_out_dst_port <= d[NOC_DATA_W-81 -: 16];
        data_len            <= in_len;
        if (in_len < 16'(BY)) bus.in_out_num_blocks <= '0;
      end
      if (state == REQ && fire) begin
        bus.in_out_num_blocks <= d[NOC_DATA_W-1 -: NUM_BLOCKS_W];
        cnt                   <= '0;
      end
      if (state == DATA && fire) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_udp_rs_encode_in_datap.sv
// tb_udp_rs_encode_in_datap: random and directed UDP RX messages checked against a message-level model
module tb_udp_rs_encode_in_datap;
  localparam int W = 512, NB = 8, BY = 64, PW = 6, CW = 520;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  udp_rs_encode_in_datap_if #(.NOC_DATA_W(W), .NUM_BLOCKS_W(NB)) u_if ();
  udp_rs_encode_in_datap #(.NOC_DATA_W(W), .NUM_BLOCKS_W(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
  typedef struct packed {logic [31:0] s, d; logic [15:0] sp, dp, len; logic [NB-1:0] nb;} meta_t;
  typedef struct packed {logic [W-1:0] d; logic l; logic [PW-1:0] p;} flit_t;
  meta_t mq[$];
  flit_t fq[$];
  int checks = 0, fails = 0, nmeta = 0, nenc = 0, nlast = 0, msgs = 0, enc_mode = 0, meta_delay = 0, mcnt = 0;
  logic [PW-1:0] lpad;
  bit gap_en = 0;
  task automatic chk(input string n, input logic [CW-1:0] a, input logic [CW-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic int exp_flits(input int len);
    return len <= BY ? 0 : (len - BY + BY - 1) / BY;
  endfunction
  function automatic int exp_pad(input int len);
    int r;
    r = (len - BY) % BY;
    return (len <= BY || r == 0) ? 0 : BY - r;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  always @(negedge clk) begin
    u_if.encoder_in_data_rdy = enc_mode == 0 ? 1'b1 : enc_mode == 1 ? ~u_if.encoder_in_data_rdy : 1'($urandom_range(1));
    mcnt = u_if.in_out_meta_val ? mcnt + 1 : 0;
    u_if.out_in_meta_rdy = u_if.in_out_meta_val && mcnt > meta_delay;
  end
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (u_if.in_out_meta_val) begin
        chk("mout_noc_rdy", u_if.udp_app_in_noc0_ctovr_rdy, 0);
        if (mq.size() == 0) chk("meta_unexpected", 1, 0);
        else begin
          chk("meta", {u_if.in_out_src_ip, u_if.in_out_dst_ip, u_if.in_out_src_port, u_if.in_out_dst_port,
                       u_if.in_out_data_len, u_if.in_out_num_blocks}, mq[0]);
          if (u_if.out_in_meta_rdy) begin
            nmeta++;
            void'(mq.pop_front());
          end
        end
      end
      if (u_if.in_encoder_data_val) chk("enc_rdy_pass", u_if.udp_app_in_noc0_ctovr_rdy, u_if.encoder_in_data_rdy);
      if (u_if.in_encoder_data_val && u_if.encoder_in_data_rdy) begin
        if (fq.size() == 0) chk("enc_unexpected", 1, 0);
        else begin
          chk("enc_flit", {u_if.in_encoder_data, u_if.in_encoder_data_last, u_if.in_encoder_data_padbytes}, fq[0]);
          void'(fq.pop_front());
        end
        nenc++;
        if (u_if.in_encoder_data_last) begin
          nlast++;
          lpad = u_if.in_encoder_data_padbytes;
        end
      end
    end
  end
  task automatic put(input logic [W-1:0] d);
    int t = 0;
    bit ok;
    do begin
      @(negedge clk);
      u_if.noc0_ctovr_udp_app_in_val = 1;
      u_if.noc0_ctovr_udp_app_in_data = d;
      #1 ok = u_if.udp_app_in_noc0_ctovr_rdy;
      @(posedge clk);
      t++;
    end while (!ok && t < 200);
    if (!ok) chk("put_timeout", 0, 1);
  endtask
  task automatic gap();
    if (gap_en && $urandom_range(3) == 0) begin
      @(negedge clk);
      u_if.noc0_ctovr_udp_app_in_val = 0;
    end
  endtask
  task automatic chk_zero_outs(input string n);
    chk({n, "_noc_rdy"}, u_if.udp_app_in_noc0_ctovr_rdy, 0);
    chk({n, "_meta_val"}, u_if.in_out_meta_val, 0);
    chk({n, "_enc_val"}, u_if.in_encoder_data_val, 0);
    chk({n, "_meta_regs"}, {u_if.in_out_src_ip, u_if.in_out_data_len, u_if.in_out_num_blocks}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    u_if.noc0_ctovr_udp_app_in_val = 1;
    #1 rst_n = 0;
    #1 chk_zero_outs("midrst");
    chk("midrst_last", {u_if.in_encoder_data_last, u_if.in_encoder_data_padbytes}, 0);
    @(negedge clk);
    u_if.noc0_ctovr_udp_app_in_val = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("midrst_release_rdy", u_if.udp_app_in_noc0_ctovr_rdy, 1);
  endtask
  task automatic send(input int len, input int nb, input int abort_at);
    meta_t m;
    flit_t f;
    logic [W-1:0] d;
    int nf;
    m.s = $urandom; m.d = $urandom; m.sp = 16'($urandom); m.dp = 16'($urandom);
    m.len = 16'(len);
    m.nb = len < BY ? '0 : NB'(nb);
    mq.push_back(m);
    msgs++;
    put(rnd());
    gap();
    d = rnd();
    d[W-1 -: 32] = m.s; d[W-33 -: 32] = m.d; d[W-65 -: 16] = m.sp; d[W-81 -: 16] = m.dp; d[W-97 -: 16] = m.len;
    put(d);
    gap();
    if (len >= BY) begin
      d = rnd();
      d[W-1 -: NB] = NB'(nb);
      put(d);
      gap();
    end
    nf = exp_flits(len);
    for (int i = 0; i < nf; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      f.d = rnd();
      f.l = i == nf - 1;
      f.p = f.l ? PW'(exp_pad(len)) : '0;
      fq.push_back(f);
      put(f.d);
      gap();
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    u_if.noc0_ctovr_udp_app_in_val = 0;
    while ((mq.size() != 0 || fq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("idle_timeout", 0, 1);
    @(negedge clk);
    #3 chk("back_in_hdr_rdy", u_if.udp_app_in_noc0_ctovr_rdy, 1);
  endtask
  task automatic run_dir(input int len, input int nb, input int en, input int ep);
    int n0, l0;
    n0 = nenc;
    l0 = nlast;
    send(len, nb, -1);
    wait_idle();
    chk($sformatf("flits_len%0d", len), nenc - n0, en);
    chk($sformatf("lasts_len%0d", len), nlast - l0, en != 0);
    if (en != 0) chk($sformatf("pad_len%0d", len), lpad, ep);
  endtask
  initial begin
    u_if.noc0_ctovr_udp_app_in_val = 0;
    u_if.noc0_ctovr_udp_app_in_data = '0;
    u_if.encoder_in_data_rdy = 1;
    u_if.out_in_meta_rdy = 0;
    #12 chk_zero_outs("reset");
    @(negedge clk);
    rst_n = 1;
    #1 chk("reset_release_rdy", u_if.udp_app_in_noc0_ctovr_rdy, 1);
    run_dir(192, 3, 2, 0);
    run_dir(160, 7, 2, 32);
    run_dir(64, 9, 0, 0);
    run_dir(20, 5, 0, 0);
    enc_mode = 1;
    meta_delay = 5;
    run_dir(320, 2, 4, 0);
    enc_mode = 0;
    meta_delay = 0;
    send(320, 4, 1);
    run_dir(130, 1, 2, 62);
    send(200, 11, -1);
    send(20, 12, -1);
    send(64, 13, -1);
    send(129, 14, -1);
    wait_idle();
    gap_en = 1;
    enc_mode = 2;
    for (int i = 0; i < 30; i++) begin
      meta_delay = $urandom_range(0, 3);
      send($urandom_range(0, 600), $urandom_range(0, 255), -1);
    end
    wait_idle();
    chk("meta_count", nmeta, msgs);
    chk("meta_queue_empty", mq.size(), 0);
    chk("flit_queue_empty", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
